// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M multiply/divide types and op decode helpers
package riscv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    // funct3 bit 2 separates the divide group from the multiply group
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // MUL is listed as signed too: its low word is the same either way
    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - sign correction and result word selection for the muldiv unit
module muldiv_sign_fix
    import riscv_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic [2*SIZE-1:0] acc,
    input  logic [2:0]        op,
    input  logic              neg_a,
    input  logic              neg_b,
    input  logic              div0,
    input  logic              ovf,
    output logic [SIZE-1:0]   word
);

    logic [2*SIZE-1:0] prod;
    logic [SIZE-1:0]   quo;
    logic [SIZE-1:0]   rem;

    // Magnitudes were computed unsigned; restore signs, then pick the word the op asks for
    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quo  = (neg_a ^ neg_b) ? -acc[SIZE-1:0] : acc[SIZE-1:0];
        rem  = neg_a ? -acc[2*SIZE-1:SIZE] : acc[2*SIZE-1:SIZE];
        word = '0;
        case (op)
            MUL:                word = prod[SIZE-1:0];
            MULH, MULHSU, MULHU: word = prod[2*SIZE-1:SIZE];
            // div0 must not be negated by a negative dividend; all ones regardless
            DIV, DIVU:          word = div0 ? '1 : (ovf ? {1'b1, {(SIZE-1){1'b0}}} : quo);
            default:            word = ovf ? '0 : rem;
        endcase
    end

endmodule

// File: rtl/unidad_muldiv.sv
// rtl/unidad_muldiv.sv - iterative RV32M multiply/divide unit with start/busy/done handshake
module unidad_muldiv
    import riscv_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    start,
    input  logic [2:0]              op,
    input  logic [SIZE-1:0]         rs1_data,
    input  logic [SIZE-1:0]         rs2_data,
    input  logic [$clog2(SIZE)-1:0] rd_in,
    input  logic                    flush,
    output logic                    busy,
    output logic                    done,
    output logic [SIZE-1:0]         result,
    output logic [$clog2(SIZE)-1:0] rd_out,
    output logic                    reg_write
);

    localparam int RW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_FIX  = FIX;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        state;
    logic [2:0]        op_q;
    logic [RW-1:0]     rd_q;
    logic [SIZE-1:0]   opa;
    logic [SIZE-1:0]   opb;
    logic [2*SIZE-1:0] acc;
    logic [CW-1:0]     cnt;
    logic              prep;
    logic              neg_a;
    logic              neg_b;
    logic              div0;
    logic              ovf;

    logic              a_neg_in;
    logic              b_neg_in;
    logic [SIZE-1:0]   abs_a;
    logic [SIZE-1:0]   abs_b;
    logic [SIZE:0]     mul_sum;
    logic [SIZE+1:0]   div_diff;
    logic [2*SIZE-1:0] acc_next;
    logic [SIZE-1:0]   fix_word;

    // Operand magnitudes for the request currently on the inputs
    always_comb begin
        a_neg_in = is_signed_a(op) && rs1_data[SIZE-1];
        b_neg_in = is_signed_b(op) && rs2_data[SIZE-1];
        abs_a    = a_neg_in ? -rs1_data : rs1_data;
        abs_b    = b_neg_in ? -rs2_data : rs2_data;
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum  = {1'b0, acc[2*SIZE-1:SIZE]} + (acc[0] ? {1'b0, opb} : {(SIZE+1){1'b0}});
        div_diff = {1'b0, acc[2*SIZE-1:SIZE-1]} - {2'b00, opb};
        acc_next = '0;
        if (is_div(op_q)) begin
            if (div_diff[SIZE+1])
                acc_next = {acc[2*SIZE-2:0], 1'b0};
            else
                acc_next = {div_diff[SIZE-1:0], acc[SIZE-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[SIZE-1:1]};
        end
    end

    muldiv_sign_fix #(
        .SIZE(SIZE)
    ) u_sign_fix (
        .acc   (acc),
        .op    (op_q),
        .neg_a (neg_a),
        .neg_b (neg_b),
        .div0  (div0),
        .ovf   (ovf),
        .word  (fix_word)
    );

    // Control FSM and datapath registers; the first CALC cycle loads the shift register,
    // the following SIZE cycles iterate, which fixes the latency for every op
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            rd_q   <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            cnt    <= '0;
            prep   <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_q  <= op;
                        rd_q  <= rd_in;
                        opa   <= abs_a;
                        opb   <= abs_b;
                        neg_a <= a_neg_in;
                        neg_b <= b_neg_in;
                        div0  <= is_div(op) && (rs2_data == '0);
                        ovf   <= ((op == DIV) || (op == REM)) &&
                                 (rs1_data == {1'b1, {(SIZE-1){1'b0}}}) && (rs2_data == '1);
                        cnt   <= CW'(SIZE - 1);
                        prep  <= 1'b1;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        prep  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (prep) begin
                        acc  <= {{SIZE{1'b0}}, opa};
                        prep <= 1'b0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - CW'(1);
                        if (cnt == '0)
                            state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        result <= fix_word;
                        rd_out <= rd_q;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode straight from the state; x0 is never written back
    always_comb begin
        busy      = (state == ST_CALC) || (state == ST_FIX);
        done      = (state == ST_DONE);
        reg_write = done && (rd_out != '0);
    end

endmodule

// File: tb/tb_unidad_muldiv.sv
// tb/tb_unidad_muldiv.sv - self-checking bench for unidad_muldiv with a reference model
module tb_unidad_muldiv;
    import riscv_pkg::*;

    localparam int SIZE = 32;

    logic        CLK;
    logic        RESET_N;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        reg_write;

    int vectors    = 0;
    int miscompares = 0;
    logic [31:0] last_exp = '0;
    logic [4:0]  last_rd  = '0;

    unidad_muldiv #(.SIZE(SIZE)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .start     (start),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_in     (rd_in),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out),
        .reg_write (reg_write)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      p;
        logic [63:0] a64;
        logic [63:0] b64;
        logic [63:0] r64;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        a64 = {32'b0, a};
        b64 = {32'b0, b};
        r64 = '0;
        case (o)
            MUL:    begin p = sa * sb; r64 = p; return r64[31:0]; end
            MULH:   begin p = sa * sb; r64 = p; return r64[63:32]; end
            MULHSU: begin p = sa * ub; r64 = p; return r64[63:32]; end
            MULHU:  begin r64 = a64 * b64; return r64[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; r64 = p; return r64[31:0];
            end
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; r64 = p; return r64[31:0];
            end
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 200));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, optionally pulse start mid-flight, and check latency, result and write-back tag
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input string tag, input bit stray);
        int n;
        n = -1;
        @(negedge CLK);
        start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0; op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
        check({tag, " busy"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 60; i++) begin
            start = stray && (i == 10);
            @(posedge CLK);
            @(negedge CLK);
            if (done) begin
                n = i;
                break;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(SIZE + 2));
        check({tag, " result"}, result, exp);
        check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
        check({tag, " reg_write"}, 32'(reg_write), 32'(rd != 0));
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        @(negedge CLK);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " held"}, result, exp);
        last_exp = exp;
        last_rd  = rd;
    endtask

    initial begin
        int          dones;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rr;

        RESET_N = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_in = '0; flush = 1'b0;
        #3 RESET_N = 1'b0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", 32'(rd_out), 32'd0);
        check("reset reg_write", 32'(reg_write), 32'd0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;

        do_op(MUL,   32'd7,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, "mul", 1'b0);
        do_op(MULH,  32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, "mulh", 1'b1);
        do_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, "mulhu", 1'b0);
        do_op(DIV,   32'hFFFF_FFF9, 32'd2,         5'd5, 32'hFFFF_FFFD, "div", 1'b1);
        do_op(REM,   32'hFFFF_FFF9, 32'd2,         5'd5, 32'hFFFF_FFFF, "rem", 1'b0);
        do_op(DIVU,  32'd100,       32'd7,         5'd0, 32'd14,        "divu_x0", 1'b0);
        do_op(REMU,  32'd100,       32'd7,         5'd9, 32'd2,         "remu", 1'b1);
        do_op(DIV,   32'd1234,      32'd0,         5'd3, 32'hFFFF_FFFF, "div0", 1'b0);
        do_op(REM,   32'd5,         32'd0,         5'd3, 32'd5,         "rem0", 1'b0);
        do_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, "div_ovf", 1'b0);
        do_op(REM,   32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'd0,         "rem_ovf", 1'b0);

        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom);
            ra = pick_operand();
            rb = pick_operand();
            rr = 5'($urandom);
            do_op(ro, ra, rb, rr, ref_model(ro, ra, rb), "rand", k[0]);
        end

        // Flush five cycles into CALC: no done, result and tag keep the previous values
        @(negedge CLK);
        start = 1'b1; op = MUL; rs1_data = 32'd3; rs2_data = 32'd3; rd_in = 5'd11;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (done) dones++;
        end
        check("flush no_done", 32'(dones), 32'd0);
        check("flush result", result, last_exp);
        check("flush rd_out", 32'(rd_out), 32'(last_rd));

        // Start together with flush in IDLE is rejected
        @(negedge CLK);
        start = 1'b1; flush = 1'b1; op = DIVU; rs1_data = 32'd9; rs2_data = 32'd3; rd_in = 5'd2;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        check("idle_flush busy", 32'(busy), 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (done) dones++;
        end
        check("idle_flush no_done", 32'(dones), 32'd0);

        // Asynchronous reset in the middle of CALC
        @(negedge CLK);
        start = 1'b1; op = DIV; rs1_data = 32'd50; rs2_data = 32'd5; rd_in = 5'd6;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (9) @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("async_rst busy", 32'(busy), 32'd0);
        check("async_rst done", 32'(done), 32'd0);
        check("async_rst result", result, 32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        do_op(DIV, 32'd50, 32'd5, 5'd6, 32'd10, "after_rst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
